sdr_cfg_sched: RTL and testbench

- Control-plane sequencer between the serial byte receiver and the SDR datapath.
- Consumes received bytes, frames them into 5-byte commands (header + 4 payload bytes), and validates each frame.
- Schedules validated writes into three datapath configuration registers: tuner frequency, control bits and gain.
- Holds each commit until the datapath signals it can accept a reconfiguration; handles resync, inter-byte timeout and error counting.

---
 rtl/sdr_cfg_sched.sv | 190 +++++++++++++++++++
 tb/tb_sdr_cfg_sched.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sdr_cfg_sched.sv
// rtl/sdr_cfg_sched.sv - frames received bytes into commands and schedules datapath config commits
module sdr_cfg_sched #(
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 13
) (
  input  logic        sclk,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        cfg_busy,
  output logic [31:0] tuner_freq,
  output logic [3:0]  ctrl_bits,
  output logic [7:0]  gain,
  output logic        cfg_stb,
  output logic [1:0]  cfg_sel,
  output logic        pending,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {HUNT, DATA, CHECK, COMMIT} state_t;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state, state_n;
  logic [7:0]       hdr, hdr_n;
  logic [6:0]       pl [4];
  logic [6:0]       pl_n [4];
  logic [1:0]       idx, idx_n;
  logic [CNT_W-1:0] timer, timer_n;
  // rx_act: a second frame is being assembled while a commit is pending
  logic             rx_act, act_n;
  logic [31:0]      sh_word, sh_word_n;
  logic [1:0]       sh_cmd, sh_cmd_n;
  logic             pending_n;
  logic             commit, err_inc;
  logic             asm_on, start, frame_done, tmo;
  logic [31:0]      buf_word, live_word;
  logic             hdr_ok;

  // The assembly buffer is shared by the first frame (DATA) and the second frame (COMMIT)
  assign asm_on   = (state == DATA) || rx_act;
  assign hdr_ok   = (hdr[6:4] <= 3'd2);
  assign buf_word = {hdr[3], pl[3], hdr[2], pl[2], hdr[1], pl[1], hdr[0], pl[0]};
  // In COMMIT the 4th payload byte is validated in the cycle it arrives
  assign live_word = {hdr[3], rx_byte[6:0], hdr[2], pl[2], hdr[1], pl[1], hdr[0], pl[0]};

  // Next-state, frame assembly, timeout and commit decisions
  always_comb begin
    state_n    = state;
    hdr_n      = hdr;
    pl_n       = pl;
    idx_n      = idx;
    timer_n    = timer;
    act_n      = rx_act;
    sh_word_n  = sh_word;
    sh_cmd_n   = sh_cmd;
    pending_n  = pending;
    commit     = 1'b0;
    err_inc    = 1'b0;
    start      = 1'b0;
    frame_done = 1'b0;
    tmo        = 1'b0;

    if (asm_on) begin
      if (rx_valid) begin
        timer_n = '0;
        if (rx_byte[7]) begin
          // header mid-frame: count the loss and restart on the new header
          err_inc = 1'b1;
          hdr_n   = rx_byte;
          idx_n   = 2'd0;
        end else begin
          pl_n[idx]  = rx_byte[6:0];
          idx_n      = idx + 2'd1;
          frame_done = (idx == 2'd3);
        end
      end else if (timer == TMO_LAST) begin
        tmo     = 1'b1;
        err_inc = 1'b1;
        timer_n = '0;
      end else begin
        timer_n = timer + 1'b1;
      end
    end else if (rx_valid && rx_byte[7]) begin
      start   = 1'b1;
      hdr_n   = rx_byte;
      idx_n   = 2'd0;
      timer_n = '0;
    end

    case (state)
      HUNT: begin
        if (start) state_n = DATA;
      end
      DATA: begin
        if (tmo)             state_n = HUNT;
        else if (frame_done) state_n = CHECK;
      end
      CHECK: begin
        if (hdr_ok) begin
          sh_word_n = buf_word;
          sh_cmd_n  = hdr[5:4];
          pending_n = 1'b1;
          act_n     = start;
          state_n   = COMMIT;
        end else begin
          err_inc = 1'b1;
          state_n = start ? DATA : HUNT;
        end
      end
      COMMIT: begin
        act_n = start | (rx_act & ~tmo & ~frame_done);
        if (!cfg_busy) begin
          commit = 1'b1;
          if (frame_done && hdr_ok) begin
            // a new frame validated as the old one left: it becomes the next pending commit
            sh_word_n = live_word;
            sh_cmd_n  = hdr[5:4];
          end else begin
            if (frame_done) err_inc = 1'b1;
            pending_n = 1'b0;
            state_n   = act_n ? DATA : HUNT;
            act_n     = 1'b0;
          end
        end else if (frame_done) begin
          // latest validated frame replaces the waiting one; either way a frame is lost
          err_inc = 1'b1;
          if (hdr_ok) begin
            sh_word_n = live_word;
            sh_cmd_n  = hdr[5:4];
          end
        end
      end
      default: state_n = HUNT;
    endcase
  end

  // State register
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_n;
  end

  // Frame buffer, shadow word and timer
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      hdr     <= '0;
      pl      <= '{default: '0};
      idx     <= '0;
      timer   <= '0;
      rx_act  <= 1'b0;
      sh_word <= '0;
      sh_cmd  <= '0;
      pending <= 1'b0;
    end else begin
      hdr     <= hdr_n;
      pl      <= pl_n;
      idx     <= idx_n;
      timer   <= timer_n;
      rx_act  <= act_n;
      sh_word <= sh_word_n;
      sh_cmd  <= sh_cmd_n;
      pending <= pending_n;
    end
  end

  // Configuration registers, strobe and saturating error counter
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      tuner_freq <= '0;
      ctrl_bits  <= '0;
      gain       <= '0;
      cfg_stb    <= 1'b0;
      cfg_sel    <= '0;
      err_cnt    <= '0;
    end else begin
      cfg_stb <= commit;
      if (commit) begin
        cfg_sel <= sh_cmd;
        case (sh_cmd)
          2'd0:    tuner_freq <= sh_word;
          2'd1:    ctrl_bits  <= sh_word[3:0];
          default: gain       <= sh_word[7:0];
        endcase
      end
      if (err_inc && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_sdr_cfg_sched.sv
// tb/tb_sdr_cfg_sched.sv - directed self-checking bench for sdr_cfg_sched
module tb_sdr_cfg_sched;

  localparam int TMO = 4096;

  logic        sclk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        cfg_busy;
  logic [31:0] tuner_freq;
  logic [3:0]  ctrl_bits;
  logic [7:0]  gain;
  logic        cfg_stb;
  logic [1:0]  cfg_sel;
  logic        pending;
  logic [7:0]  err_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int err_exp = 0;

  sdr_cfg_sched #(.TIMEOUT_CYC(TMO), .CNT_W(13)) dut (
    .sclk(sclk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .cfg_busy(cfg_busy), .tuner_freq(tuner_freq), .ctrl_bits(ctrl_bits),
    .gain(gain), .cfg_stb(cfg_stb), .cfg_sel(cfg_sel), .pending(pending),
    .err_cnt(err_cnt)
  );

  always #5 sclk = ~sclk;

  // called at a negedge; byte is consumed on the following posedge
  task automatic send(input logic [7:0] b);
    rx_byte = b;
    rx_valid = 1'b1;
    @(negedge sclk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] h, input logic [7:0] p0, input logic [7:0] p1,
                            input logic [7:0] p2, input logic [7:0] p3);
    send(h); send(p0); send(p1); send(p2); send(p3);
  endtask

  task automatic count_stb(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge sclk);
      if (cfg_stb) c++;
    end
  endtask

  task automatic test_reset;
    n_cmp++; if (tuner_freq !== 32'h0) begin n_bad++; $display("FAIL reset_freq got %h want 0", tuner_freq); end
    n_cmp++; if (ctrl_bits !== 4'h0) begin n_bad++; $display("FAIL reset_ctrl got %h want 0", ctrl_bits); end
    n_cmp++; if (gain !== 8'h0) begin n_bad++; $display("FAIL reset_gain got %h want 0", gain); end
    n_cmp++; if ({cfg_stb, cfg_sel, pending} !== 4'b0) begin n_bad++; $display("FAIL reset_flags got %b want 0000", {cfg_stb, cfg_sel, pending}); end
    n_cmp++; if (err_cnt !== 8'h0) begin n_bad++; $display("FAIL reset_err got %0d want 0", err_cnt); end
  endtask

  task automatic test_freq;
    int c;
    send_frame(8'h80, 8'h78, 8'h56, 8'h34, 8'h12);
    n_cmp++; if (cfg_stb !== 1'b0) begin n_bad++; $display("FAIL freq_early_stb got %b want 0", cfg_stb); end
    @(negedge sclk);
    n_cmp++; if ({pending, cfg_stb} !== 2'b10) begin n_bad++; $display("FAIL freq_pending got %b want 10", {pending, cfg_stb}); end
    @(negedge sclk);
    n_cmp++; if (cfg_stb !== 1'b1) begin n_bad++; $display("FAIL freq_stb_latency got %b want 1", cfg_stb); end
    n_cmp++; if (tuner_freq !== 32'h12345678) begin n_bad++; $display("FAIL freq_value got %h want 12345678", tuner_freq); end
    n_cmp++; if ({cfg_sel, pending} !== 3'b000) begin n_bad++; $display("FAIL freq_sel_pend got %b want 000", {cfg_sel, pending}); end
    n_cmp++; if ({ctrl_bits, gain} !== 12'h0) begin n_bad++; $display("FAIL freq_others got %h want 000", {ctrl_bits, gain}); end
    count_stb(8, c);
    n_cmp++; if (c !== 0) begin n_bad++; $display("FAIL freq_stb_width got %0d extra want 0", c); end
  endtask

  task automatic test_ctrl_gain;
    int c;
    send_frame(8'h9F, 8'h05, 8'h00, 8'h00, 8'h00);
    count_stb(6, c);
    n_cmp++; if (c !== 1) begin n_bad++; $display("FAIL ctrl_stb_count got %0d want 1", c); end
    n_cmp++; if (ctrl_bits !== 4'h5) begin n_bad++; $display("FAIL ctrl_value got %h want 5", ctrl_bits); end
    n_cmp++; if (cfg_sel !== 2'd1) begin n_bad++; $display("FAIL ctrl_sel got %0d want 1", cfg_sel); end
    send_frame(8'hA0, 8'h7F, 8'h00, 8'h00, 8'h00);
    count_stb(6, c);
    n_cmp++; if (c !== 1) begin n_bad++; $display("FAIL gain_stb_count got %0d want 1", c); end
    n_cmp++; if (gain !== 8'h7F) begin n_bad++; $display("FAIL gain_value got %h want 7f", gain); end
    n_cmp++; if (cfg_sel !== 2'd2) begin n_bad++; $display("FAIL gain_sel got %0d want 2", cfg_sel); end
    n_cmp++; if ({tuner_freq, ctrl_bits} !== {32'h12345678, 4'h5}) begin n_bad++; $display("FAIL gain_others got %h want 123456785", {tuner_freq, ctrl_bits}); end
  endtask

  task automatic test_busy;
    int c;
    cfg_busy = 1'b1;
    send_frame(8'h85, 8'h11, 8'h22, 8'h33, 8'h44);
    count_stb(10, c);
    n_cmp++; if (c !== 0) begin n_bad++; $display("FAIL busy_no_stb got %0d want 0", c); end
    n_cmp++; if (pending !== 1'b1) begin n_bad++; $display("FAIL busy_pending got %b want 1", pending); end
    n_cmp++; if (tuner_freq !== 32'h12345678) begin n_bad++; $display("FAIL busy_hold got %h want 12345678", tuner_freq); end
    cfg_busy = 1'b0;
    @(negedge sclk);
    n_cmp++; if ({cfg_stb, pending} !== 2'b10) begin n_bad++; $display("FAIL busy_release got %b want 10", {cfg_stb, pending}); end
    n_cmp++; if (tuner_freq !== 32'h44B32291) begin n_bad++; $display("FAIL busy_value got %h want 44b32291", tuner_freq); end
    count_stb(5, c);
    n_cmp++; if (c !== 0) begin n_bad++; $display("FAIL busy_single_stb got %0d extra want 0", c); end
  endtask

  task automatic test_timeout;
    int c;
    send(8'h80); send(8'h01);
    repeat (TMO) @(negedge sclk);
    send(8'h02);
    err_exp = err_exp + 1;
    count_stb(8, c);
    n_cmp++; if (c !== 0) begin n_bad++; $display("FAIL tmo_no_commit got %0d want 0", c); end
    n_cmp++; if (err_cnt !== err_exp[7:0]) begin n_bad++; $display("FAIL tmo_err got %0d want %0d", err_cnt, err_exp); end
    send(8'h80); send(8'h01);
    repeat (TMO - 1) @(negedge sclk);
    send(8'h02); send(8'h03); send(8'h04);
    count_stb(6, c);
    n_cmp++; if (c !== 1) begin n_bad++; $display("FAIL tmo_edge_commit got %0d want 1", c); end
    n_cmp++; if (tuner_freq !== 32'h04030201) begin n_bad++; $display("FAIL tmo_edge_value got %h want 04030201", tuner_freq); end
    n_cmp++; if (err_cnt !== err_exp[7:0]) begin n_bad++; $display("FAIL tmo_edge_err got %0d want %0d", err_cnt, err_exp); end
  endtask

  task automatic test_resync;
    int c;
    send(8'h80); send(8'h01);
    send_frame(8'h80, 8'h0A, 8'h0B, 8'h0C, 8'h0D);
    err_exp = err_exp + 1;
    count_stb(6, c);
    n_cmp++; if (c !== 1) begin n_bad++; $display("FAIL resync_commit got %0d want 1", c); end
    n_cmp++; if (tuner_freq !== 32'h0D0C0B0A) begin n_bad++; $display("FAIL resync_value got %h want 0d0c0b0a", tuner_freq); end
    n_cmp++; if (err_cnt !== err_exp[7:0]) begin n_bad++; $display("FAIL resync_err got %0d want %0d", err_cnt, err_exp); end
  endtask

  task automatic test_overwrite;
    int c;
    cfg_busy = 1'b1;
    send_frame(8'hA0, 8'h11, 8'h00, 8'h00, 8'h00);
    repeat (2) @(negedge sclk);
    send_frame(8'h90, 8'h03, 8'h00, 8'h00, 8'h00);
    err_exp = err_exp + 1;
    count_stb(4, c);
    n_cmp++; if ({c[0], pending} !== 2'b01 || c !== 0) begin n_bad++; $display("FAIL ovw_pending got stb=%0d pend=%b want 0/1", c, pending); end
    n_cmp++; if (err_cnt !== err_exp[7:0]) begin n_bad++; $display("FAIL ovw_err got %0d want %0d", err_cnt, err_exp); end
    cfg_busy = 1'b0;
    count_stb(6, c);
    n_cmp++; if (c !== 1) begin n_bad++; $display("FAIL ovw_stb_count got %0d want 1", c); end
    n_cmp++; if ({cfg_sel, ctrl_bits, gain} !== {2'd1, 4'h3, 8'h7F}) begin n_bad++; $display("FAIL ovw_regs got %h want 137f", {cfg_sel, ctrl_bits, gain}); end
    n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL ovw_pending_clear got %b want 0", pending); end
  endtask

  task automatic test_bad_cmd;
    int c;
    send_frame(8'hF0, 8'h00, 8'h00, 8'h00, 8'h00);
    err_exp = err_exp + 1;
    count_stb(6, c);
    n_cmp++; if (c !== 0) begin n_bad++; $display("FAIL badcmd_no_stb got %0d want 0", c); end
    n_cmp++; if (err_cnt !== err_exp[7:0]) begin n_bad++; $display("FAIL badcmd_err got %0d want %0d", err_cnt, err_exp); end
    for (int i = 0; i < 300; i++) begin
      send_frame(8'hF0, 8'h00, 8'h00, 8'h00, 8'h00);
      @(negedge sclk);
    end
    err_exp = (err_exp + 300 > 255) ? 255 : err_exp + 300;
    repeat (3) @(negedge sclk);
    n_cmp++; if (err_cnt !== err_exp[7:0]) begin n_bad++; $display("FAIL err_saturate got %0d want %0d", err_cnt, err_exp); end
  endtask

  task automatic test_reset_in_commit;
    int c;
    cfg_busy = 1'b1;
    send_frame(8'h80, 8'h21, 8'h22, 8'h23, 8'h24);
    repeat (3) @(negedge sclk);
    n_cmp++; if (pending !== 1'b1) begin n_bad++; $display("FAIL rstc_pending_before got %b want 1", pending); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({tuner_freq, ctrl_bits, gain} !== 44'h0) begin n_bad++; $display("FAIL rstc_regs got %h want 0", {tuner_freq, ctrl_bits, gain}); end
    n_cmp++; if ({cfg_stb, cfg_sel, pending, err_cnt} !== 12'h0) begin n_bad++; $display("FAIL rstc_flags got %h want 0", {cfg_stb, cfg_sel, pending, err_cnt}); end
    @(negedge sclk);
    rst_n = 1'b1;
    cfg_busy = 1'b0;
    count_stb(10, c);
    n_cmp++; if (c !== 0) begin n_bad++; $display("FAIL rstc_no_stb got %0d want 0", c); end
    n_cmp++; if ({pending, tuner_freq} !== 33'h0) begin n_bad++; $display("FAIL rstc_discard got %h want 0", {pending, tuner_freq}); end
  endtask

  initial begin
    rst_n = 1'b0;
    rx_byte = 8'h00;
    rx_valid = 1'b0;
    cfg_busy = 1'b0;
    repeat (3) @(negedge sclk);
    test_reset;
    rst_n = 1'b1;
    @(negedge sclk);
    test_freq;
    test_ctrl_gain;
    test_busy;
    test_timeout;
    test_resync;
    test_overwrite;
    test_bad_cmd;
    test_reset_in_commit;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
